dot_vector_loader: RTL

Upstream feeder for the dot-product top-level wrapper. It accepts a byte-wide valid/ready stream of operand elements and packs each group of VECTOR_WIDTH elements into one DATA_WIDTH word. A-vectors are written into operand memory 1 and B-vectors into operand memory 2 at a shared pair address. After the configured number of pairs has been written, it pulses start_processing to launch the wrapper.

---
 rtl/dot_vector_loader_pkg.sv | 19 +
 rtl/dot_vector_loader_vector_packer.sv | 39 +++
 rtl/dot_vector_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dot_vector_loader_pkg.sv
// Shared definitions for the dot-product datapath: operand geometry,
// memory sizing and the loader state encoding.
package dot_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int VECTOR_WIDTH         = 4;
  localparam int VECTOR_ELEMENT_WIDTH = 8;
  localparam int ADDR_WIDTH           = 5;
  localparam int MEM_SIZE             = 32;
  localparam int RESULT_WIDTH         = 2 * VECTOR_ELEMENT_WIDTH + $clog2(VECTOR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_LAUNCH
  } loader_state_t;

endpackage

// File: rtl/dot_vector_loader_vector_packer.sv
// Byte shift-in packer: the first element of a vector ends up in the LSBs.
// word/word_valid show the completed vector on the cycle its last element is accepted.
module vector_packer #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEMS  = 4,
  localparam int WORD_WIDTH = ELEM_WIDTH * NUM_ELEMS,
  localparam int CNT_WIDTH  = $clog2(NUM_ELEMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [ELEM_WIDTH-1:0] in_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam logic [CNT_WIDTH-1:0] LAST_ELEM = CNT_WIDTH'(NUM_ELEMS - 1);

  logic [WORD_WIDTH-1:0] shift_q;
  logic [CNT_WIDTH-1:0]  elem_q;

  // New elements enter at the top, so earlier ones drift down towards bit 0.
  assign word       = {in_data, shift_q[WORD_WIDTH-1:ELEM_WIDTH]};
  assign word_valid = in_valid && (elem_q == LAST_ELEM);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      elem_q  <= '0;
    end else if (in_valid) begin
      shift_q <= word;
      elem_q  <= word_valid ? '0 : elem_q + 1'b1;
    end
  end

endmodule

// File: rtl/dot_vector_loader.sv
// Stream-to-operand-memory loader: packs A/B vectors from a byte stream into
// two operand memories, then pulses start_processing once the job is complete.
module dot_vector_loader #(
  parameter int DATA_WIDTH           = dot_pkg::DATA_WIDTH,
  parameter int VECTOR_WIDTH         = dot_pkg::VECTOR_WIDTH,
  parameter int VECTOR_ELEMENT_WIDTH = dot_pkg::VECTOR_ELEMENT_WIDTH,
  parameter int ADDR_WIDTH           = dot_pkg::ADDR_WIDTH,
  parameter int MEM_SIZE             = dot_pkg::MEM_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic [ADDR_WIDTH:0]             cfg_count,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [VECTOR_ELEMENT_WIDTH-1:0] s_data,
  input  logic                            s_last,
  output logic                            write_en1,
  output logic [ADDR_WIDTH-1:0]           write_address1,
  output logic [DATA_WIDTH-1:0]           data_in1,
  output logic                            write_en2,
  output logic [ADDR_WIDTH-1:0]           write_address2,
  output logic [DATA_WIDTH-1:0]           data_in2,
  output logic                            start_processing,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  import dot_pkg::*;

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  loader_state_t             state_q, state_d;
  logic [ADDR_WIDTH:0]       count_q;
  logic [ADDR_WIDTH-1:0]     pair_q;
  logic [DATA_WIDTH-1:0]     word;
  logic                      word_valid;
  logic                      xfer, count_ok, last_pair, final_byte, frame_err, pack_clear;
  logic                      we1_d, we2_d, start_d, error_d;

  assign s_ready    = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign busy       = (state_q != ST_IDLE);
  assign xfer       = s_valid && s_ready;
  assign count_ok   = (cfg_count != '0) && (cfg_count <= MAX_COUNT);
  assign last_pair  = (({1'b0, pair_q} + 1'b1) == count_q);
  assign final_byte = (state_q == ST_LOAD_B) && word_valid && last_pair;
  // s_last must coincide exactly with the job's final byte; any disagreement aborts.
  assign frame_err  = xfer && (s_last != final_byte);
  assign pack_clear = (state_q == ST_IDLE) || frame_err;

  vector_packer #(
    .ELEM_WIDTH (VECTOR_ELEMENT_WIDTH),
    .NUM_ELEMS  (VECTOR_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .in_valid   (xfer),
    .in_data    (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (load_start && count_ok) state_d = ST_LOAD_A;
      ST_LOAD_A: begin
        if (frame_err)       state_d = ST_IDLE;
        else if (word_valid) state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        if (frame_err)       state_d = ST_IDLE;
        else if (word_valid) state_d = last_pair ? ST_LAUNCH : ST_LOAD_A;
      end
      ST_LAUNCH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we1_d   = (state_q == ST_LOAD_A) && word_valid && !frame_err;
    we2_d   = (state_q == ST_LOAD_B) && word_valid && !frame_err;
    start_d = (state_q == ST_LAUNCH);
    error_d = ((state_q == ST_IDLE) && load_start && !count_ok) || frame_err;
  end

  // Strobes, addresses and data are registered; addresses/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q          <= '0;
      pair_q           <= '0;
      write_en1        <= 1'b0;
      write_en2        <= 1'b0;
      write_address1   <= '0;
      write_address2   <= '0;
      data_in1         <= '0;
      data_in2         <= '0;
      start_processing <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      write_en1        <= we1_d;
      write_en2        <= we2_d;
      start_processing <= start_d;
      done             <= start_d;
      error            <= error_d;
      if ((state_q == ST_IDLE) && load_start && count_ok) begin
        count_q <= cfg_count;
        pair_q  <= '0;
      end else if (we2_d) begin
        pair_q  <= pair_q + 1'b1;
      end
      if (we1_d) begin
        write_address1 <= pair_q;
        data_in1       <= word;
      end
      if (we2_d) begin
        write_address2 <= pair_q;
        data_in2       <= word;
      end
    end
  end

endmodule
